// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: execute command codes, status layout and FSM encodings
// shared by seq_alu and alu_flags.
package seq_alu_pkg;

  localparam int LEN_EXECUTE_COMMAND = 4;
  localparam int LEN_STATUS = 4;

  typedef logic [LEN_EXECUTE_COMMAND-1:0] exe_cmd_t;

  localparam exe_cmd_t EXE_ADD = 4'd0;
  localparam exe_cmd_t EXE_ADC = 4'd1;
  localparam exe_cmd_t EXE_SUB = 4'd2;
  localparam exe_cmd_t EXE_SBC = 4'd3;
  localparam exe_cmd_t EXE_CMP = 4'd4;
  localparam exe_cmd_t EXE_LDR = 4'd5;
  localparam exe_cmd_t EXE_STR = 4'd6;
  localparam exe_cmd_t EXE_MOV = 4'd7;
  localparam exe_cmd_t EXE_MVN = 4'd8;
  localparam exe_cmd_t EXE_AND = 4'd9;
  localparam exe_cmd_t EXE_ORR = 4'd10;
  localparam exe_cmd_t EXE_EOR = 4'd11;
  localparam exe_cmd_t EXE_TST = 4'd12;
  localparam exe_cmd_t EXE_MUL = 4'd13;

  // Bit positions inside the {N,Z,C,V} status word
  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  localparam logic [1:0] SEQ_ALU_IDLE = 2'd0;
  localparam logic [1:0] SEQ_ALU_MUL  = 2'd1;
  localparam logic [1:0] SEQ_ALU_HOLD = 2'd2;

endpackage

// File: rtl/alu_flags.sv
// alu_flags: combinational N/Z/C/V generator, shared by the
// single-cycle and multiply result paths of seq_alu.
module alu_flags
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]      res_i,
  input  logic                  a_sign_i,
  input  logic                  b_sign_i,
  input  logic                  c_i,
  input  logic                  add_i,
  input  logic                  sub_i,
  output logic [LEN_STATUS-1:0] nzcv_o
);

  logic sr;
  logic v_add;
  logic v_sub;

  assign sr    = res_i[WIDTH-1];
  assign v_add = add_i && (a_sign_i == b_sign_i) && (sr != a_sign_i);
  assign v_sub = sub_i && (a_sign_i != b_sign_i) && (sr != a_sign_i);

  always_comb begin
    nzcv_o       = '0;
    nzcv_o[ST_N] = sr;
    nzcv_o[ST_Z] = (res_i == '0);
    nzcv_o[ST_C] = c_i;
    nzcv_o[ST_V] = v_add || v_sub;
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked execute-stage ALU with registered output.
// Iterative shift-add multiply is built when SEQ_ALU_MUL_EN is defined.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LEN_EXECUTE_COMMAND-1:0] command,
  input  logic [WIDTH-1:0]               op1,
  input  logic [WIDTH-1:0]               op2,
  input  logic [LEN_STATUS-1:0]          status_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               result,
  output logic [LEN_STATUS-1:0]          status_bits,
  output logic                           busy
);

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      res_q;
  logic [LEN_STATUS-1:0] st_q;
  logic                  accept;
  logic                  is_mul;
  logic                  load;
  logic                  mul_st;

  logic [WIDTH:0]        a_x, b_x, cin_x, bor_x, wide;
  logic                  c_sel, add_k, sub_k;

  logic [WIDTH-1:0]      acc_nx;
  logic [WIDTH-1:0]      fl_res;
  logic                  fl_c, fl_add, fl_sub;
  logic [LEN_STATUS-1:0] nzcv;

  logic                  unused_status;

  assign unused_status = ^{status_in[ST_N], status_in[ST_Z],
                           status_in[ST_V]};

  assign mul_st   = (state_q == SEQ_ALU_MUL);
  assign in_ready = !flush && ((state_q == SEQ_ALU_IDLE) ||
                    ((state_q == SEQ_ALU_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  assign a_x   = {1'b0, op1};
  assign b_x   = {1'b0, op2};
  assign cin_x = {{WIDTH{1'b0}}, status_in[ST_C]};
  assign bor_x = {{WIDTH{1'b0}}, !status_in[ST_C]};

  always_comb begin
    wide  = '0;
    c_sel = 1'b0;
    add_k = 1'b0;
    sub_k = 1'b0;
    unique case (command)
      EXE_ADD: begin
        wide  = a_x + b_x;
        c_sel = 1'b1;
        add_k = 1'b1;
      end
      EXE_ADC: begin
        wide  = a_x + b_x + cin_x;
        c_sel = 1'b1;
        add_k = 1'b1;
      end
      EXE_SUB, EXE_CMP: begin
        wide  = a_x - b_x;
        c_sel = 1'b1;
        sub_k = 1'b1;
      end
      EXE_SBC: begin
        wide  = a_x - b_x - bor_x;
        c_sel = 1'b1;
        sub_k = 1'b1;
      end
      EXE_LDR, EXE_STR: begin
        wide  = a_x + b_x;
        c_sel = 1'b1;
      end
      EXE_MOV:          wide = b_x;
      EXE_MVN:          wide = {1'b0, ~op2};
      EXE_AND, EXE_TST: wide = a_x & b_x;
      EXE_ORR:          wide = a_x | b_x;
      EXE_EOR:          wide = a_x ^ b_x;
      default:          wide = '0;
    endcase
  end

  // One flag generator; the multiply path never sets C or V
  assign fl_res = mul_st ? acc_nx : wide[WIDTH-1:0];
  assign fl_c   = !mul_st && c_sel && wide[WIDTH];
  assign fl_add = !mul_st && add_k;
  assign fl_sub = !mul_st && sub_k;

  alu_flags #(
    .WIDTH(WIDTH)
  ) u_flags (
    .res_i   (fl_res),
    .a_sign_i(op1[WIDTH-1]),
    .b_sign_i(op2[WIDTH-1]),
    .c_i     (fl_c),
    .add_i   (fl_add),
    .sub_i   (fl_sub),
    .nzcv_o  (nzcv)
  );

`ifdef SEQ_ALU_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             mul_done;

  assign is_mul   = (command == EXE_MUL);
  assign acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done = mul_st && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= op1;
      mplier_q <= op2;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH - 1);
    end else if (mul_st) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_nx;
      cnt_q    <= cnt_q - CW'(1);
    end
  end
`else
  assign is_mul = 1'b0;
  assign acc_nx = '0;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      SEQ_ALU_IDLE, SEQ_ALU_HOLD: begin
        if (accept) begin
          state_d = is_mul ? SEQ_ALU_MUL : SEQ_ALU_HOLD;
          load    = !is_mul;
        end else if ((state_q == SEQ_ALU_HOLD) && out_ready) begin
          state_d = SEQ_ALU_IDLE;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      SEQ_ALU_MUL: begin
        if (mul_done) begin
          state_d = SEQ_ALU_HOLD;
          load    = 1'b1;
        end
      end
`endif
      default: state_d = SEQ_ALU_IDLE;
    endcase
    if (flush) begin
      state_d = SEQ_ALU_IDLE;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_ALU_IDLE;
      res_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        res_q <= fl_res;
        st_q  <= nzcv;
      end
    end
  end

  assign out_valid   = (state_q == SEQ_ALU_HOLD);
  assign busy        = mul_st;
  assign result      = res_q;
  assign status_bits = st_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=32, covering
// flags, back-pressure, flush, reset and the optional multiply.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready;
  logic         out_valid, out_ready, busy;
  logic [3:0]   command, status_in, status_bits;
  logic [W-1:0] op1, op2, result;

  int passed = 0;
  int total  = 0;

  logic [W+3:0] sb[$];
  logic [W+3:0] exp_v;

  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  always #5 clk = ~clk;

  seq_alu #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .command    (command),
    .op1        (op1),
    .op2        (op2),
    .status_in  (status_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .status_bits(status_bits),
    .busy       (busy)
  );

  function automatic logic [W+3:0] model(logic [3:0] cmd,
                                         logic [W-1:0] a,
                                         logic [W-1:0] b,
                                         logic cin);
    longint ua, ub, sa, sbv, u, s;
    logic [W-1:0] r;
    logic c, v;
    bit ar, ov;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = $signed(a);
    sbv = $signed(b);
    u = 0; s = 0; c = 0; v = 0; ar = 0; ov = 0;
    case (cmd)
      EXE_ADD: begin u = ua + ub; s = sa + sbv; ar = 1; ov = 1; end
      EXE_ADC: begin
        u = ua + ub + longint'(cin);
        s = sa + sbv + longint'(cin);
        ar = 1; ov = 1;
      end
      EXE_SUB, EXE_CMP: begin
        u = ua - ub; s = sa - sbv; ar = 1; ov = 1;
      end
      EXE_SBC: begin
        u = ua - ub - (cin ? 64'sd0 : 64'sd1);
        s = sa - sbv - (cin ? 64'sd0 : 64'sd1);
        ar = 1; ov = 1;
      end
      EXE_LDR, EXE_STR: begin u = ua + ub; ar = 1; end
      EXE_MOV: u = ub;
      EXE_MVN: u = longint'({32'd0, ~b});
      EXE_AND, EXE_TST: u = longint'({32'd0, a & b});
      EXE_ORR: u = longint'({32'd0, a | b});
      EXE_EOR: u = longint'({32'd0, a ^ b});
`ifdef SEQ_ALU_MUL_EN
      EXE_MUL: u = ua * ub;
`endif
      default: u = 0;
    endcase
    r = u[W-1:0];
    if (ar) c = u[W];
    if (ov) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {r, r[W-1], (r == '0), c, v};
  endfunction

  task automatic drive(logic [3:0] c, logic [W-1:0] a,
                       logic [W-1:0] b, logic ci);
    in_valid  = 1'b1;
    command   = c;
    op1       = a;
    op2       = b;
    status_in = {2'b00, ci, 1'b0};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    command = '0; op1 = '0; op2 = '0; status_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_valid: got %b want 0", out_valid);
    else passed++;
    total++;
    if ({result, status_bits} !== '0)
      $display("FAIL reset_out: got %h/%b want 0/0000", result, status_bits);
    else passed++;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_hs: busy %b in_ready %b want 0 1", busy, in_ready);
    else passed++;
  endtask

  task automatic test_vectors();
    vec_t v[$];
    v.push_back('{EXE_ADD, 32'h7fffffff, 32'h1, 1'b0, 32'h80000000, 4'b1001});
    v.push_back('{EXE_SUB, 32'd5, 32'd5, 1'b0, 32'd0, 4'b0100});
    v.push_back('{EXE_SBC, 32'd3, 32'd1, 1'b0, 32'd1, 4'b0000});
    v.push_back('{EXE_SBC, 32'd3, 32'd1, 1'b1, 32'd2, 4'b0000});
    v.push_back('{EXE_ADC, 32'hffffffff, 32'd0, 1'b1, 32'd0, 4'b0110});
    v.push_back('{EXE_SUB, 32'd0, 32'd1, 1'b0, 32'hffffffff, 4'b1010});
    v.push_back('{EXE_SUB, 32'h80000000, 32'd1, 1'b0, 32'h7fffffff, 4'b0001});
    v.push_back('{EXE_MVN, 32'd9, 32'd0, 1'b0, 32'hffffffff, 4'b1000});
    v.push_back('{EXE_CMP, 32'd1, 32'd2, 1'b0, 32'hffffffff, 4'b1010});
    v.push_back('{EXE_LDR, 32'd100, 32'd4, 1'b0, 32'd104, 4'b0000});
    v.push_back('{EXE_AND, 32'hff00ff00, 32'h0f0f0f0f, 1'b0, 32'h0f000f00, 4'b0000});
    v.push_back('{4'd15, 32'd7, 32'd7, 1'b1, 32'd0, 4'b0100});
`ifndef SEQ_ALU_MUL_EN
    v.push_back('{EXE_MUL, 32'd3, 32'd4, 1'b0, 32'd0, 4'b0100});
`endif
    out_ready = 1'b1;
    foreach (v[i]) begin
      @(posedge clk); #1;
      drive(v[i].c, v[i].a, v[i].b, v[i].ci);
      sb.push_back({v[i].r, v[i].f});
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      exp_v = sb.pop_front();
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b0)
        $display("FAIL vec%0d_timing: valid %b busy %b want 1 0",
                 i, out_valid, busy);
      else passed++;
      total++;
      if ({result, status_bits} !== exp_v)
        $display("FAIL vec%0d_value: got %h/%b want %h/%b", i,
                 result, status_bits, exp_v[W+3:4], exp_v[3:0]);
      else passed++;
    end
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic test_mul();
    logic [W-1:0] ma[3];
    logic [W-1:0] mb[3];
    int n, bad;
    ma[0] = 32'h0000ffff; mb[0] = 32'h00010001;
    ma[1] = $urandom;     mb[1] = $urandom;
    ma[2] = 32'hffffffff; mb[2] = 32'hffffffff;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(EXE_MUL, ma[i], mb[i], 1'b1);
      if (i == 0) sb.push_back({32'hffffffff, 4'b1000});
      else sb.push_back(model(EXE_MUL, ma[i], mb[i], 1'b1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0; bad = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
        if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
        @(negedge clk);
        n++;
      end
      total++;
      if (n != W)
        $display("FAIL mul%0d_latency: got %0d want %0d", i, n, W);
      else passed++;
      total++;
      if (bad != 0)
        $display("FAIL mul%0d_busy: got %0d bad cycles want 0", i, bad);
      else passed++;
      exp_v = sb.pop_front();
      total++;
      if ({result, status_bits, busy} !== {exp_v, 1'b0})
        $display("FAIL mul%0d_value: got %h/%b want %h/%b", i,
                 result, status_bits, exp_v[W+3:4], exp_v[3:0]);
      else passed++;
    end
  endtask
`endif

  task automatic test_backpressure();
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(EXE_ADD, 32'd10, 32'd20, 1'b0);
    sb.push_back(model(EXE_ADD, 32'd10, 32'd20, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_v = sb[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, result, status_bits} !== {2'b10, exp_v})
        $display("FAIL bp_hold%0d: got v%b r%b %h/%b want v1 r0 %h/%b",
                 k, out_valid, in_ready, result, status_bits,
                 exp_v[W+3:4], exp_v[3:0]);
      else passed++;
    end
    out_ready = 1'b1;
    drive(EXE_MOV, 32'd0, 32'h55, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_ready: got %b want 1", in_ready);
    else passed++;
    void'(sb.pop_front());
    sb.push_back(model(EXE_MOV, 32'd0, 32'h55, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_v = sb.pop_front();
    total++;
    if ({out_valid, result, status_bits} !== {1'b1, exp_v})
      $display("FAIL bp_mov: got v%b %h/%b want v1 %h/%b", out_valid,
               result, status_bits, exp_v[W+3:4], exp_v[3:0]);
    else passed++;
  endtask

  task automatic test_flush();
    int seen;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(EXE_ADD, 32'd1, 32'd2, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    drive(EXE_MOV, 32'd0, 32'd7, 1'b0);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL flush_block: in_ready %b want 0", in_ready);
    else passed++;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_hold: valid %b ready %b want 0 1",
               out_valid, in_ready);
    else passed++;
    out_ready = 1'b1;
`ifdef SEQ_ALU_MUL_EN
    @(posedge clk); #1;
    drive(EXE_MUL, 32'd123, 32'd456, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010)
      $display("FAIL flush_mul: v%b r%b b%b want 0 1 0",
               out_valid, in_ready, busy);
    else passed++;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0)
      $display("FAIL flush_mul_quiet: got %0d active cycles want 0", seen);
    else passed++;
`else
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0)
      $display("FAIL flush_quiet: got %0d valid cycles want 0", seen);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(EXE_ORR, 32'hf0, 32'h0f, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({out_valid, busy, result, status_bits} !== '0)
      $display("FAIL rst_hold: v%b b%b %h/%b want all 0",
               out_valid, busy, result, status_bits);
    else passed++;
    out_ready = 1'b1;
`ifdef SEQ_ALU_MUL_EN
    @(posedge clk); #1;
    drive(EXE_MUL, 32'd77, 32'd99, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({out_valid, busy, result, status_bits, in_ready} !== 38'd1)
      $display("FAIL rst_mul: v%b b%b %h/%b r%b want 0 0 0/0 1",
               out_valid, busy, result, status_bits, in_ready);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    logic [W-1:0] pick[5];
    logic [3:0] c;
    logic [W-1:0] a, b;
    logic ci;
    out_ready = 1'b1;
    for (int i = 0; i <= N; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        exp_v = sb.pop_front();
        total++;
        if ({out_valid, result, status_bits} !== {1'b1, exp_v})
          $display("FAIL b2b%0d: got v%b %h/%b want v1 %h/%b", i - 1,
                   out_valid, result, status_bits,
                   exp_v[W+3:4], exp_v[3:0]);
        else passed++;
      end
      if (i < N) begin
        pick[0] = 32'h0;        pick[1] = 32'h7fffffff;
        pick[2] = 32'h80000000; pick[3] = 32'hffffffff;
        pick[4] = $urandom;
        c  = 4'($urandom_range(0, 15));
`ifdef SEQ_ALU_MUL_EN
        if (c == EXE_MUL) c = EXE_EOR;
`endif
        a  = pick[$urandom_range(0, 4)];
        b  = pick[$urandom_range(0, 4)];
        ci = 1'($urandom_range(0, 1));
        drive(c, a, b, ci);
        sb.push_back(model(c, a, b, ci));
        total++;
        if (in_ready !== 1'b1)
          $display("FAIL b2b%0d_ready: got %b want 1", i, in_ready);
        else passed++;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
`ifdef SEQ_ALU_MUL_EN
    test_mul();
`endif
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Handshaked, parametrised-width execute-stage ALU that replaces the purely combinational ALU. Each operation is accepted through a valid/ready input port and returned through a registered valid/ready output port. It supports the full `EXE_*` command set from `ISA.v` at single-cycle latency, plus an optional iterative multiply (`EXE_MUL`). It sits between the ID/EX register and the EX/MEM register, and stalls the pipeline through `in_ready` while it is busy.

## Interface
- `WIDTH`, 32: operand/result width; legal values ≥ 4. All flag logic uses bit `WIDTH-1` as the sign bit.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous kill of the in-flight or held operation.
- `in_valid` in 1: operand/command valid.
- `in_ready` out 1: block can accept this cycle.
- `command` in `LEN_EXECUTE_COMMAND`: `EXE_*` code.
- `op1`, `op2` in `WIDTH`: operands.
- `status_in` in `LEN_STATUS`: {N,Z,C,V}. Only C is used (ADC/SBC carry-in). Sampled at acceptance.
- `out_valid` out 1: `result` and `status_bits` valid.
- `out_ready` in 1: consumer takes the result.
- `result` out `WIDTH`: registered result.
- `status_bits` out `LEN_STATUS`: registered {N,Z,C,V}.
- `busy` out 1: high in state MUL.

## Operation
- **States:**
  - IDLE: output empty.
  - MUL: iterating.
  - HOLD: result presented.
- **Acceptance** happens when `in_valid & in_ready`.
  - `in_ready = !flush & (IDLE | (HOLD & out_ready))`, which allows back-to-back single-cycle ops.
- **Transitions:**
  - IDLE or HOLD, with acceptance of a non-MUL op → HOLD (result registered).
  - IDLE or HOLD, with acceptance of MUL → MUL.
  - HOLD, with `out_ready` and no acceptance → IDLE.
  - MUL → HOLD once the final iteration has been processed.
- **Arithmetic:** computed at `WIDTH+1` bits with zero-extended operands.
  - C = bit `WIDTH` for ADD, ADC, SUB, SBC, CMP, LDR, STR.
  - SBC = op1 − op2 − (C_in ? 0 : 1). ADC adds C_in.
  - MOV, MVN, AND, ORR, EOR, TST: C = 0. MVN result is ~op2 truncated to `WIDTH`.
  - LDR/STR return op1 + op2 (address).
- **Flags:**
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - V is signed overflow for ADD/ADC (same-sign operands, result sign differs) and for SUB/SBC/CMP (operand signs differ, result sign ≠ op1 sign). V = 0 otherwise.
- **Unknown commands:** result 0, flags 0100.
- **MUL:** shift-add, one multiplier bit per cycle, down-counter of width clog2(`WIDTH`).
  - Result is the low `WIDTH` bits of the product.
  - N and Z as defined above; C = 0, V = 0.
- **Reset:** `rst` → IDLE, `out_valid` = 0, `result` = 0, `status_bits` = 0000, `busy` = 0, counter = 0.
- **Priority:** `rst` > `flush` > normal operation.
  - `flush` → IDLE and `out_valid` = 0 at the next edge.
  - A flushed MUL is discarded with no output.
  - Acceptance is blocked in the flush cycle.
- **Output stability:** outputs are held unchanged while `out_valid & !out_ready`.

## Timing
- **Single-cycle ops:** accepted at edge t0; `out_valid` is high after edge t0.
- **MUL:** accepted at t0; iterations occur at edges t0+1 … t0+`WIDTH`; `out_valid` is high after edge t0+`WIDTH`. `busy` is high over the same interval.
- **Throughput:** one single-cycle op per clock while `out_ready` = 1.
- **No combinational paths** from `in_*` to `out_*`. `in_ready` depends combinationally only on state, `out_ready` and `flush`.

## Configuration
- **`SEQ_ALU_MUL_EN` defined:** `EXE_MUL` is decoded, and the MUL state, multiplicand/accumulator registers and counter are built.
- **Undefined:** `EXE_MUL` is treated as an unknown command (single-cycle, result 0, flags 0100). No MUL state or registers exist, and `busy` is tied to 0.

## Structure
- The shared header `ISA.v` holds:
  - `LEN_EXECUTE_COMMAND`, `LEN_STATUS` and all `EXE_*` codes;
  - the new `EXE_MUL` code, distinct from the existing codes;
  - the state encodings `SEQ_ALU_IDLE`, `SEQ_ALU_MUL`, `SEQ_ALU_HOLD`.
- One sub-module is natural: `alu_flags`, a combinational N/Z/C/V generator parametrised by `WIDTH`. It is shared by the single-cycle and MUL result paths.

## Test plan
- **Signed-overflow ADD** (`WIDTH`=32): ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, NZCV=1001, `out_valid` high 1 cycle after accept.
- **Zero SUB and borrowing SBC:** SUB 5 − 5 → 0, NZCV=0100. SBC 3 − 1 with C_in=0 → 1, NZCV=0000.
- **MUL** (macro on): 0x0000FFFF × 0x00010001 → 0xFFFFFFFF, NZCV=1000, `out_valid` exactly 32 cycles after accept, `busy` high for those 32 cycles, `in_ready`=0 throughout.
- **Back-pressure:** ADD result with `out_ready`=0 for 5 cycles → `result`/`status_bits` stable, `in_ready`=0. Then `out_ready`=1 together with a new MOV → MOV result is presented next cycle with no bubble.
- **Flush and reset mid-MUL:** `flush` at iteration 10 → `out_valid` never rises, state IDLE and `in_ready`=1 on the following cycle. `rst` mid-MUL → all outputs 0 next cycle.
- **Macro off:** MUL 3 × 4 → result 0, NZCV=0100 after 1 cycle, `busy` never high.
